// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - functional-unit result ports and common data bus grouped for the CDB arbiter
interface cdb_arbiter_if #(
    parameter int N_UNITS = 4,
    parameter int CDB_W   = 40
);
    logic [N_UNITS*CDB_W-1:0] u_data;
    logic [N_UNITS-1:0]       u_valid;
    logic [N_UNITS-1:0]       u_ready;
    logic                     cdb_stall;
    logic                     clear;
    logic [CDB_W-1:0]         cdb;
    logic                     cdb_valid;

    // master: units plus CDB consumer side; slave: the arbiter itself
    modport master (
        output u_data, u_valid, cdb_stall, clear,
        input  u_ready, cdb, cdb_valid
    );

    modport slave (
        input  u_data, u_valid, cdb_stall, clear,
        output u_ready, cdb, cdb_valid
    );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin result arbiter driving the common data bus (optional CDB_ARB_STATS_EN conflict counter)
module cdb_arbiter #(
    parameter int N_UNITS = 4,
    parameter int CDB_W   = 40      // RSV_ID_W (8) + DATA_W (32)
) (
    input  logic         clk,
    input  logic         rst,
    cdb_arbiter_if.slave bus
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [31:0]  conflict_cnt
`endif
);
    localparam int PTR_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] next_ptr;
    logic             grant_any;
    logic [CDB_W-1:0] grant_data;
    int               idx;

    // Walk the search order backwards so the first valid unit after rr_ptr is the last one written.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (!rst && !bus.clear && !bus.cdb_stall) begin
            for (int k = N_UNITS - 1; k >= 0; k--) begin
                idx = (int'(rr_ptr) + k) % N_UNITS;
                if (bus.u_valid[PTR_W'(idx)]) begin
                    grant_any = 1'b1;
                    grant_idx = PTR_W'(idx);
                end
            end
        end
    end

    always_comb begin
        bus.u_ready = '0;
        grant_data  = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            if (grant_idx == PTR_W'(k)) begin
                bus.u_ready[k] = grant_any;
                grant_data     = bus.u_data[k*CDB_W +: CDB_W];
            end
        end
    end

    assign next_ptr = (grant_idx == PTR_W'(N_UNITS - 1)) ? '0 : grant_idx + 1'b1;

    // cdb keeps its last value when idle; only cdb_valid qualifies it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.cdb_valid <= 1'b0;
            bus.cdb       <= '0;
            rr_ptr        <= '0;
        end else if (bus.clear) begin
            bus.cdb_valid <= 1'b0;
            rr_ptr        <= '0;
        end else if (grant_any) begin
            bus.cdb_valid <= 1'b1;
            bus.cdb       <= grant_data;
            rr_ptr        <= next_ptr;
        end else begin
            bus.cdb_valid <= 1'b0;
        end
    end

`ifdef CDB_ARB_STATS_EN
    // Counts grants made while at least one other unit was left waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (grant_any && ($countones(bus.u_valid) >= 2)) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized self-checking bench for cdb_arbiter against a rule-level model
module tb_cdb_arbiter;
    localparam int N = 4;
    localparam int W = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.N_UNITS(N), .CDB_W(W)) bus ();

    logic [W-1:0] pk [N];
    assign bus.u_data = {pk[3], pk[2], pk[1], pk[0]};

`ifdef CDB_ARB_STATS_EN
    logic [31:0] conflict_cnt;
    cdb_arbiter #(.N_UNITS(N), .CDB_W(W)) dut (
        .clk(clk), .rst(rst), .bus(bus), .conflict_cnt(conflict_cnt)
    );
`else
    cdb_arbiter #(.N_UNITS(N), .CDB_W(W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    int n_cmp = 0;
    int n_err = 0;

    int           m_ptr   = 0;
    logic [W-1:0] m_cdb   = '0;
    bit           m_valid = 1'b0;
    logic [31:0]  m_cnt   = '0;

    function automatic int model_winner();
        int idx;
        if (rst || bus.clear || bus.cdb_stall) return -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (bus.u_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = model_winner();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic tick(output int g);
        logic [N-1:0] v;
        logic [W-1:0] d;
        bit clr;
        g   = model_winner();
        v   = bus.u_valid;
        clr = bus.clear;
        d   = (g >= 0) ? pk[g] : '0;
        @(posedge clk);
        if (clr) begin
            m_valid = 1'b0;
            m_ptr   = 0;
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_cdb   = d;
            m_ptr   = (g + 1) % N;
            if ($countones(v) >= 2) m_cnt = m_cnt + 32'd1;
        end else begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.u_valid = 4'b1111;
        bus.cdb_stall = 1'b0;
        bus.clear = 1'b0;
        for (int u = 0; u < N; u++) pk[u] = W'(u + 1);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.u_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b expected 0000", bus.u_ready); end
        n_cmp++;
        if (bus.cdb_valid !== 1'b0) begin n_err++; $display("FAIL reset_cdb_valid: got %b expected 0", bus.cdb_valid); end
        n_cmp++;
        if (bus.cdb !== '0) begin n_err++; $display("FAIL reset_cdb: got %h expected 0", bus.cdb); end
`ifdef CDB_ARB_STATS_EN
        n_cmp++;
        if (conflict_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", conflict_cnt); end
`endif
        rst = 1'b0;
        bus.u_valid = 4'b0000;
    endtask

    task automatic test_single();
        int g;
        bus.u_valid = 4'b0001;
        pk[0] = {8'd3, 32'h0000_00AA};
        #1;
        n_cmp++;
        if (bus.u_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b expected 0001", bus.u_ready); end
        tick(g);
        bus.u_valid = 4'b0000;
        n_cmp++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb !== {8'd3, 32'h0000_00AA})
            begin n_err++; $display("FAIL single_bcast: got v=%b %h expected v=1 %h", bus.cdb_valid, bus.cdb, {8'd3, 32'h0000_00AA}); end
        tick(g);
        n_cmp++;
        if (bus.cdb_valid !== 1'b0) begin n_err++; $display("FAIL single_drop: got %b expected 0", bus.cdb_valid); end
    endtask

    task automatic test_round_robin();
        int g;
        int exp_u;
        logic [W-1:0] sent;
        for (int u = 0; u < N; u++) pk[u] = {8'(u + 10), $urandom};
        bus.u_valid = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            exp_u = (1 + c) % N;
            #1;
            n_cmp++;
            if (bus.u_ready !== 4'(1 << exp_u)) begin n_err++; $display("FAIL rr_ready[%0d]: got %b expected %b", c, bus.u_ready, 4'(1 << exp_u)); end
            sent = pk[exp_u];
            tick(g);
            pk[exp_u] = {8'(exp_u + 10), $urandom};
            n_cmp++;
            if (bus.cdb_valid !== 1'b1 || bus.cdb !== sent) begin n_err++; $display("FAIL rr_bcast[%0d]: got v=%b %h expected v=1 %h", c, bus.cdb_valid, bus.cdb, sent); end
        end
        bus.u_valid = 4'b0000;
    endtask

    task automatic test_wrap();
        int g;
        bus.u_valid = 4'b0100;
        #1;
        n_cmp++;
        if (bus.u_ready !== 4'b0100) begin n_err++; $display("FAIL wrap_pre: got %b expected 0100", bus.u_ready); end
        tick(g);
        bus.u_valid = 4'b1001;
        #1;
        n_cmp++;
        if (bus.u_ready !== 4'b1000) begin n_err++; $display("FAIL wrap_unit3: got %b expected 1000", bus.u_ready); end
        tick(g);
        bus.u_valid = 4'b0001;
        #1;
        n_cmp++;
        if (bus.u_ready !== 4'b0001) begin n_err++; $display("FAIL wrap_unit0: got %b expected 0001", bus.u_ready); end
        tick(g);
        n_cmp++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb !== pk[0]) begin n_err++; $display("FAIL wrap_bcast: got v=%b %h expected v=1 %h", bus.cdb_valid, bus.cdb, pk[0]); end
    endtask

    task automatic test_stall();
        int g;
        bus.u_valid = 4'b0110;
        bus.cdb_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (bus.u_ready !== 4'b0000) begin n_err++; $display("FAIL stall_ready[%0d]: got %b expected 0000", c, bus.u_ready); end
            tick(g);
            n_cmp++;
            if (bus.cdb_valid !== 1'b0) begin n_err++; $display("FAIL stall_valid[%0d]: got %b expected 0", c, bus.cdb_valid); end
        end
        bus.cdb_stall = 1'b0;
        #1;
        n_cmp++;
        if (bus.u_ready !== 4'b0010) begin n_err++; $display("FAIL stall_resume: got %b expected 0010", bus.u_ready); end
        tick(g);
        n_cmp++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb !== pk[1]) begin n_err++; $display("FAIL stall_bcast: got v=%b %h expected v=1 %h", bus.cdb_valid, bus.cdb, pk[1]); end
        bus.u_valid = 4'b0100;
        tick(g);
        bus.u_valid = 4'b0000;
    endtask

    task automatic test_clear();
        int g;
        bus.u_valid = 4'b0010;
        tick(g);
        bus.u_valid = 4'b0100;
        bus.clear = 1'b1;
        #1;
        n_cmp++;
        if (bus.u_ready !== 4'b0000) begin n_err++; $display("FAIL clear_ready: got %b expected 0000", bus.u_ready); end
        tick(g);
        bus.clear = 1'b0;
        n_cmp++;
        if (bus.cdb_valid !== 1'b0) begin n_err++; $display("FAIL clear_valid: got %b expected 0", bus.cdb_valid); end
        #1;
        n_cmp++;
        if (bus.u_ready !== 4'b0100) begin n_err++; $display("FAIL clear_regrant: got %b expected 0100", bus.u_ready); end
        tick(g);
        bus.u_valid = 4'b1010;
        bus.clear = 1'b1;
        tick(g);
        bus.clear = 1'b0;
        #1;
        n_cmp++;
        if (bus.u_ready !== 4'b0010) begin n_err++; $display("FAIL clear_ptr0: got %b expected 0010", bus.u_ready); end
        tick(g);
        bus.u_valid = 4'b1000;
        tick(g);
        bus.u_valid = 4'b0000;
    endtask

    task automatic test_async_reset();
        int g;
        bus.u_valid = 4'b0100;
        tick(g);
        bus.u_valid = 4'b1111;
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.cdb_valid !== 1'b0 || bus.u_ready !== 4'b0000)
            begin n_err++; $display("FAIL async_rst: got v=%b ready=%b expected v=0 ready=0000", bus.cdb_valid, bus.u_ready); end
        m_valid = 1'b0; m_ptr = 0; m_cdb = '0; m_cnt = '0;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.u_ready !== 4'b0001) begin n_err++; $display("FAIL async_from0: got %b expected 0001", bus.u_ready); end
        tick(g);
        bus.u_valid = 4'b0000;
    endtask

    task automatic test_random();
        int g;
        logic [N-1:0] vld;
        logic [N-1:0] exp_r;
        vld = '0;
        for (int c = 0; c < 300; c++) begin
            for (int u = 0; u < N; u++)
                if (!vld[u] && $urandom_range(0, 2) == 0) begin
                    vld[u] = 1'b1;
                    pk[u] = W'({$urandom, $urandom});
                end
            bus.u_valid   = vld;
            bus.cdb_stall = ($urandom_range(0, 4) == 0);
            bus.clear     = ($urandom_range(0, 9) == 0);
            #1;
            exp_r = model_ready();
            n_cmp++;
            if (bus.u_ready !== exp_r) begin n_err++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, bus.u_ready, exp_r); end
            tick(g);
            if (g >= 0) vld[g] = 1'b0;
            n_cmp++;
            if (bus.cdb_valid !== m_valid || (m_valid && bus.cdb !== m_cdb))
                begin n_err++; $display("FAIL rand_bcast[%0d]: got v=%b %h expected v=%b %h", c, bus.cdb_valid, bus.cdb, m_valid, m_cdb); end
`ifdef CDB_ARB_STATS_EN
            n_cmp++;
            if (conflict_cnt !== m_cnt) begin n_err++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", c, conflict_cnt, m_cnt); end
`endif
        end
        bus.u_valid = '0;
        bus.cdb_stall = 1'b0;
        bus.clear = 1'b0;
    endtask

    initial begin
        test_reset();
        @(posedge clk);
        #1;
        test_single();
        test_round_robin();
        test_wrap();
        test_stall();
        test_clear();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Sits directly downstream of the functional units (ALU, FPU, load/store, branch). Each unit presents a finished result packet {RSV_ID, DATA}, CDB_W bits wide, on a valid/ready port.
- Round-robin arbitration picks at most one packet per cycle. The winner is registered and broadcast on the common data bus (cdb/cdb_valid) to every reservation station and the reorder buffer.

Parameters:
- N_UNITS, 4, number of functional-unit source ports (2..8).
- CDB_W, fcpu_pkg::CDB_W, result packet width (RSV_ID_W+DATA_W).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- u_data  input  N_UNITS*CDB_W  result packets; unit i occupies bits [i*CDB_W +: CDB_W].
- u_valid  input  N_UNITS  unit i has a result.
- u_ready  output  N_UNITS  unit i's packet is taken this cycle.
- cdb_stall  input  1  consumer (ROB full) blocks broadcast.
- clear  input  1  synchronous pipeline flush (mispredict).
- cdb  output  CDB_W  broadcast packet.
- cdb_valid  output  1  cdb holds a valid packet this cycle.

Behaviour:
- Reset (rst=1, async): cdb_valid=0, cdb=0, rr_ptr=0. u_ready is 0 whenever rst=1.
- u_ready is combinational from u_valid, rr_ptr, cdb_stall and clear. At most one bit is set (one-hot or zero).
- Grant search order: rr_ptr, rr_ptr+1, … wrapping modulo N_UNITS. The first i with u_valid[i]=1 wins.
- No grant when cdb_stall=1, clear=1, or u_valid=0.
- Transfer on unit i when u_valid[i] & u_ready[i].
- Next edge after a transfer: cdb<=u_data[i], cdb_valid<=1, rr_ptr<=(i+1) mod N_UNITS.
- No transfer: cdb_valid<=0, cdb holds its last value, rr_ptr unchanged.
- Latency: exactly 1 cycle from handshake to broadcast. Each packet is broadcast for exactly one cycle; the CDB has no backpressure beyond cdb_stall.
- Throughput: 1 packet/cycle sustained. A unit holding u_valid waits at most N_UNITS-1 grants (starvation-free).
- Units must keep u_data and u_valid stable until granted. The arbiter never takes a packet whose valid is low.
- cdb_stall=1: no grants. cdb_valid drops to 0 on the next edge; a packet registered in the same cycle the stall rises is still broadcast.
- clear=1: no grants; next edge cdb_valid<=0 and rr_ptr<=0. clear has priority over cdb_stall and valid inputs.
- Reset mid-broadcast: cdb_valid drops immediately (async) and the packet is lost; units are flushed by the same reset.
- N_UNITS=1: arbiter degenerates to a registered pass-through gated by stall/clear.

Optional Feature:
- Macro CDB_ARB_STATS_EN.
- Defined: adds output conflict_cnt, 32 bits, reset 0. It increments by 1 on each cycle where popcount(u_valid)>=2 and a grant occurs; it wraps at 2^32-1 to 0, and clear does not reset it.
- Undefined: port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Single source: u_valid=0001, u_data[0]={id 3, 0x0000_00AA} -> u_ready=0001 same cycle; next cycle cdb={3,0xAA}, cdb_valid=1; the cycle after, cdb_valid=0.
- Round-robin fairness: all 4 u_valid held high with packets A,B,C,D continuously replenished -> broadcast order A,B,C,D,A,… with one packet per cycle and no gaps.
- Pointer wrap: rr_ptr=3, u_valid=1001 -> unit 3 granted, rr_ptr becomes 0; next cycle unit 0 granted.
- Stall: cdb_stall=1 for 3 cycles with u_valid=0110 -> u_ready=0 throughout; cdb_valid=0 from the cycle after stall rises; grants resume to unit 1 when stall falls (rr_ptr=1).
- Clear: clear=1 in the cycle unit 2 is presented, rr_ptr=2 -> no handshake, cdb_valid=0, rr_ptr=0; next cycle unit 2 (still valid) is granted via search from 0.
- Async reset mid-stream: assert rst between clock edges while cdb_valid=1 -> cdb_valid=0 and u_ready=0 immediately without a clock edge; after release the first grant searches from unit 0.
